// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory BIST engine: sequencer states, LFSR
// width/seed, and the phase-dependent data mask.
package mem_bist_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    SEED,
    RD,
    DRAIN,
    DONE
  } bist_state_e;

  function automatic logic [LFSR_W-1:0] phaseMask(input logic phase);
    return {LFSR_W{phase}};
  endfunction

endpackage

// File: rtl/bist_fault_log.sv
// Deduplicating fault table: remembers the unique failing addresses seen
// during a test, counts them (saturating), flags overflow and exposes a
// combinational read port for the repair logic.
module bist_fault_log
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int FAULT_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  input  logic                             logValid_i,
  input  logic [ADDR_W-1:0]                logAddr_i,
  input  logic [$clog2(FAULT_DEPTH)-1:0]   faultSel_i,
  output logic [$clog2(FAULT_DEPTH):0]     faultCnt_o,
  output logic                             faultOvf_o,
  output logic [ADDR_W-1:0]                faultAddr_o
);

  localparam int SEL_W = $clog2(FAULT_DEPTH);
  localparam int CNT_W = SEL_W + 1;

  logic [ADDR_W-1:0]      entry_q [FAULT_DEPTH];
  logic [FAULT_DEPTH-1:0] valid_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_q;
  logic                   hit_d;
  logic                   full_d;

  // CAM-style lookup: is the incoming address already recorded in a live entry?
  always_comb begin
    hit_d = 1'b0;
    for (int i = 0; i < FAULT_DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i] == logAddr_i)) begin
        hit_d = 1'b1;
      end
    end
  end

  assign full_d = (cnt_q == CNT_W'(FAULT_DEPTH));

  // Append new unique faults in arrival order; once full, only remember that more were lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FAULT_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      valid_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      valid_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (logValid_i && !hit_d) begin
      if (!full_d) begin
        entry_q[cnt_q[SEL_W-1:0]] <= logAddr_i;
        valid_q[cnt_q[SEL_W-1:0]] <= 1'b1;
        cnt_q                     <= cnt_q + 1'b1;
      end else begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign faultCnt_o  = cnt_q;
  assign faultOvf_o  = ovf_q;
  assign faultAddr_o = valid_q[faultSel_i] ? entry_q[faultSel_i] : '0;

endmodule

// File: rtl/mem_bist_engine.sv
// Two-phase memory BIST sequencer: writes the LFSR sequence (true, then
// inverted) across the whole array, reseeds, reads it back through a
// 1-cycle-latency SRAM port and logs mismatching addresses.
module mem_bist_engine
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int FAULT_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic                             lfsr_en,
  input  logic [LFSR_W-1:0]                lfsr_out,
  output logic                             mem_cs,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [LFSR_W-1:0]                mem_wdata,
  input  logic [LFSR_W-1:0]                mem_rdata,
  output logic [$clog2(FAULT_DEPTH):0]     fault_cnt,
  output logic                             fault_ovf,
  input  logic [$clog2(FAULT_DEPTH)-1:0]   fault_sel,
  output logic [ADDR_W-1:0]                fault_addr
);

  bist_state_e        state_q;
  logic               phase_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic               lfsrEn_q;
  logic               memCs_q;
  logic               memWe_q;
  logic [LFSR_W-1:0]  expData_q;
  logic [ADDR_W-1:0]  cmpAddr_q;
  logic               cmpValid_q;

  logic               lastAddr_d;
  logic               mismatch_d;
  logic               logClear_d;
  logic               pass_d;

  assign lastAddr_d = &addr_q;
  assign mismatch_d = cmpValid_q && (mem_rdata != expData_q);
  assign logClear_d = (state_q == IDLE) && start;

  // The final compare lands in the same cycle pass is latched, so fold it in directly.
  assign pass_d = (fault_cnt == '0) && !mismatch_d;

  // Sequencer: every output is registered and set up one edge ahead of the cycle it applies to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      lfsrEn_q   <= 1'b0;
      memCs_q    <= 1'b0;
      memWe_q    <= 1'b0;
      expData_q  <= '0;
      cmpAddr_q  <= '0;
      cmpValid_q <= 1'b0;
    end else begin
      cmpValid_q <= (state_q == RD);
      if (state_q == RD) begin
        expData_q <= lfsr_out ^ phaseMask(phase_q);
        cmpAddr_q <= addr_q;
      end
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= WR;
            phase_q  <= 1'b0;
            addr_q   <= '0;
            busy_q   <= 1'b1;
            pass_q   <= 1'b0;
            memCs_q  <= 1'b1;
            memWe_q  <= 1'b1;
            lfsrEn_q <= 1'b1;
          end
        end
        WR: begin
          addr_q <= addr_q + 1'b1;
          if (lastAddr_d) begin
            state_q  <= SEED;
            memCs_q  <= 1'b0;
            memWe_q  <= 1'b0;
            lfsrEn_q <= 1'b0;
          end
        end
        SEED: begin
          state_q  <= RD;
          memCs_q  <= 1'b1;
          memWe_q  <= 1'b0;
          lfsrEn_q <= 1'b1;
        end
        RD: begin
          addr_q <= addr_q + 1'b1;
          if (lastAddr_d) begin
            state_q  <= DRAIN;
            memCs_q  <= 1'b0;
            lfsrEn_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (!phase_q) begin
            state_q  <= WR;
            phase_q  <= 1'b1;
            memCs_q  <= 1'b1;
            memWe_q  <= 1'b1;
            lfsrEn_q <= 1'b1;
          end else begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= pass_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign lfsr_en   = lfsrEn_q;
  assign mem_cs    = memCs_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = (state_q == WR) ? (lfsr_out ^ phaseMask(phase_q)) : '0;

  bist_fault_log #(
    .ADDR_W      (ADDR_W),
    .FAULT_DEPTH (FAULT_DEPTH)
  ) u_faultLog (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (logClear_d),
    .logValid_i  (mismatch_d),
    .logAddr_i   (cmpAddr_q),
    .faultSel_i  (fault_sel),
    .faultCnt_o  (fault_cnt),
    .faultOvf_o  (fault_ovf),
    .faultAddr_o (fault_addr)
  );

endmodule

// File: tb/tb_mem_bist_engine.sv
// Bench for mem_bist_engine: external LFSR, fault-injecting SRAM model,
// table-driven fault scenarios, hand-written corner sequences and random
// fault maps checked against a behavioural reference model.
module tb_mem_bist_engine;

  localparam int ADDR_W = 4;
  localparam int N      = 16;
  localparam int DEPTH  = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 3;
  localparam int NOMINAL_DONE = 69;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, pass, lfsr_en;
  logic [7:0]        lfsr_out;
  logic              mem_cs, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;
  logic [CNT_W-1:0]  fault_cnt;
  logic              fault_ovf;
  logic [SEL_W-1:0]  fault_sel;
  logic [ADDR_W-1:0] fault_addr;

  int errors = 0;
  int checks = 0;

  int   faultType [N];
  int   faultBit  [N];
  bit   lat2 = 1'b0;

  logic [7:0] lfsrReg = 8'h01;
  logic [7:0] memArr [N];
  logic [7:0] rd1 = 8'h00;
  logic [7:0] rd2 = 8'h00;

  logic [ADDR_W-1:0] wrAddr [32];
  logic [7:0]        wrData [32];
  int                wrIdx = 0;

  int               refCnt;
  bit               refOvf;
  bit               refPass;
  logic [3:0][3:0]  refTab;

  typedef struct packed {
    logic [15:0]     flipA;
    logic [15:0]     stk0A;
    logic [15:0]     stk1A;
    logic [2:0]      expCnt;
    logic            expOvf;
    logic            expPass;
    logic [3:0][3:0] expTab;
  } vec_t;

  vec_t vecs [7];

  mem_bist_engine #(.ADDR_W(ADDR_W), .FAULT_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .lfsr_en    (lfsr_en),
    .lfsr_out   (lfsr_out),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .fault_cnt  (fault_cnt),
    .fault_ovf  (fault_ovf),
    .fault_sel  (fault_sel),
    .fault_addr (fault_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsrStep(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] applyFault(input int a, input logic [7:0] d);
    logic [7:0] m;
    m = 8'h01 << faultBit[a];
    case (faultType[a])
      1:       return d ^ m;
      2:       return d & ~m;
      3:       return d | m;
      default: return d;
    endcase
  endfunction

  // External pattern generator: steps when enabled, otherwise snaps back to the seed.
  always @(posedge clk) lfsrReg <= lfsr_en ? lfsrStep(lfsrReg) : 8'h01;
  assign lfsr_out = lfsrReg;

  // Synchronous SRAM with faults applied on write and selectable 1- or 2-cycle read latency.
  always @(posedge clk) begin
    if (mem_cs && mem_we) memArr[int'(mem_addr)] <= applyFault(int'(mem_addr), mem_wdata);
    if (mem_cs && !mem_we) rd1 <= memArr[int'(mem_addr)];
    rd2 <= rd1;
  end
  assign mem_rdata = lat2 ? rd2 : rd1;

  // Record the order of writes during each test.
  always @(posedge clk) begin
    if (!busy) begin
      wrIdx <= 0;
    end else if (mem_cs && mem_we && wrIdx < 32) begin
      wrAddr[wrIdx] <= mem_addr;
      wrData[wrIdx] <= mem_wdata;
      wrIdx         <= wrIdx + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Walk both phases address by address, deciding from the fault map what the read returns.
  task automatic refModel();
    logic [7:0] seq [N];
    logic [7:0] v;
    logic [7:0] e;
    bit seen;
    v = 8'h01;
    refCnt = 0;
    refOvf = 1'b0;
    refTab = '0;
    for (int i = 0; i < N; i++) begin
      seq[i] = v;
      v = lfsrStep(v);
    end
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < N; a++) begin
        e = seq[a] ^ ((p == 1) ? 8'hFF : 8'h00);
        if (applyFault(a, e) != e) begin
          seen = 1'b0;
          for (int k = 0; k < refCnt; k++) if (int'(refTab[k]) == a) seen = 1'b1;
          if (!seen) begin
            if (refCnt < DEPTH) begin
              refTab[refCnt] = 4'(a);
              refCnt++;
            end else begin
              refOvf = 1'b1;
            end
          end
        end
      end
    end
    refPass = (refCnt == 0);
  endtask

  task automatic applyStimulus(input bit midStart, output int doneCyc);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      start = (midStart && cyc == 20) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    doneCyc = cyc;
  endtask

  task automatic checkResults(input string tag, input int dc, input int eCnt, input bit eOvf,
                              input bit ePass, input logic [3:0][3:0] eTab);
    checkOutput({tag, ".doneCycle"}, 32'(dc), 32'(NOMINAL_DONE));
    checkOutput({tag, ".pass"}, 32'(pass), 32'(ePass));
    checkOutput({tag, ".faultCnt"}, 32'(fault_cnt), 32'(eCnt));
    checkOutput({tag, ".faultOvf"}, 32'(fault_ovf), 32'(eOvf));
    for (int k = 0; k < eCnt; k++) begin
      fault_sel = SEL_W'(k);
      #1;
      checkOutput($sformatf("%s.tab%0d", tag, k), 32'(fault_addr), 32'(eTab[k]));
    end
    @(posedge clk);
    #1;
    checkOutput({tag, ".donePulse"}, 32'(done), 32'(0));
    checkOutput({tag, ".idleBusy"}, 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
  endtask

  task automatic loadVector(input vec_t v);
    for (int a = 0; a < N; a++) begin
      faultBit[a]  = 0;
      faultType[a] = v.flipA[a] ? 1 : v.stk0A[a] ? 2 : v.stk1A[a] ? 3 : 0;
    end
  endtask

  task automatic runVector(input vec_t v, input bit midStart, input string tag);
    int dc;
    loadVector(v);
    applyStimulus(midStart, dc);
    checkResults(tag, dc, int'(v.expCnt), v.expOvf, v.expPass, v.expTab);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dc;
    vecs[0] = '{flipA:16'h0000, stk0A:16'h0000, stk1A:16'h0000, expCnt:3'd0, expOvf:1'b0, expPass:1'b1,
                expTab:{4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[1] = '{flipA:16'h0000, stk0A:16'h0020, stk1A:16'h0000, expCnt:3'd1, expOvf:1'b0, expPass:1'b0,
                expTab:{4'd0, 4'd0, 4'd0, 4'd5}};
    vecs[2] = '{flipA:16'h128A, stk0A:16'h0000, stk1A:16'h0000, expCnt:3'd4, expOvf:1'b1, expPass:1'b0,
                expTab:{4'd9, 4'd7, 4'd3, 4'd1}};
    vecs[3] = '{flipA:16'h0020, stk0A:16'h0000, stk1A:16'h0000, expCnt:3'd1, expOvf:1'b0, expPass:1'b0,
                expTab:{4'd0, 4'd0, 4'd0, 4'd5}};
    vecs[4] = '{flipA:16'h0010, stk0A:16'h0002, stk1A:16'h0000, expCnt:3'd2, expOvf:1'b0, expPass:1'b0,
                expTab:{4'd0, 4'd0, 4'd1, 4'd4}};
    vecs[5] = '{flipA:16'h0001, stk0A:16'h0020, stk1A:16'h0002, expCnt:3'd3, expOvf:1'b0, expPass:1'b0,
                expTab:{4'd0, 4'd5, 4'd1, 4'd0}};
    vecs[6] = '{flipA:16'hF001, stk0A:16'h0000, stk1A:16'h0000, expCnt:3'd4, expOvf:1'b1, expPass:1'b0,
                expTab:{4'd14, 4'd13, 4'd12, 4'd0}};

    for (int a = 0; a < N; a++) begin
      faultType[a] = 0;
      faultBit[a]  = 0;
    end
    rst = 1'b1;
    start = 1'b0;
    fault_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.busy", 32'(busy), 32'(0));
    checkOutput("reset.done", 32'(done), 32'(0));
    checkOutput("reset.pass", 32'(pass), 32'(0));
    checkOutput("reset.lfsrEn", 32'(lfsr_en), 32'(0));
    checkOutput("reset.memCs", 32'(mem_cs), 32'(0));
    checkOutput("reset.memWe", 32'(mem_we), 32'(0));
    checkOutput("reset.memAddr", 32'(mem_addr), 32'(0));
    checkOutput("reset.memWdata", 32'(mem_wdata), 32'(0));
    checkOutput("reset.faultCnt", 32'(fault_cnt), 32'(0));
    checkOutput("reset.faultOvf", 32'(fault_ovf), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      runVector(vecs[i], 1'b0, $sformatf("vec%0d", i));
      if (i == 0) begin
        checkOutput("clean.wrAddr0", 32'(wrAddr[0]), 32'(0));
        checkOutput("clean.wr0", 32'(wrData[0]), 32'h01);
        checkOutput("clean.wr1", 32'(wrData[1]), 32'h02);
        checkOutput("clean.wr2", 32'(wrData[2]), 32'h04);
        checkOutput("clean.wr3", 32'(wrData[3]), 32'h08);
        checkOutput("clean.wrAddr16", 32'(wrAddr[16]), 32'(0));
        checkOutput("clean.inv0", 32'(wrData[16]), 32'hFE);
        checkOutput("clean.inv1", 32'(wrData[17]), 32'hFD);
        checkOutput("clean.inv2", 32'(wrData[18]), 32'hFB);
        checkOutput("clean.inv3", 32'(wrData[19]), 32'hF7);
      end
    end

    runVector(vecs[4], 1'b1, "startInRd");

    loadVector(vecs[2]);
    applyStimulus(1'b0, dc);
    checkOutput("preReset.faultCnt", 32'(fault_cnt), 32'(4));
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midReset.memCs", 32'(mem_cs), 32'(0));
    checkOutput("midReset.lfsrEn", 32'(lfsr_en), 32'(0));
    checkOutput("midReset.busy", 32'(busy), 32'(0));
    checkOutput("midReset.faultCnt", 32'(fault_cnt), 32'(0));
    checkOutput("midReset.faultOvf", 32'(fault_ovf), 32'(0));
    fault_sel = '0;
    #1;
    checkOutput("midReset.tab0", 32'(fault_addr), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    loadVector(vecs[0]);
    applyStimulus(1'b0, dc);
    checkOutput("rerun.wrAddr0", 32'(wrAddr[0]), 32'(0));
    checkOutput("rerun.wr0", 32'(wrData[0]), 32'h01);
    checkResults("rerun", dc, 0, 1'b0, 1'b1, '0);

    lat2 = 1'b1;
    loadVector(vecs[0]);
    applyStimulus(1'b0, dc);
    checkOutput("lat2.doneCycle", 32'(dc), 32'(NOMINAL_DONE));
    checkOutput("lat2.faultCnt", 32'(fault_cnt), 32'(DEPTH));
    checkOutput("lat2.faultOvf", 32'(fault_ovf), 32'(1));
    checkOutput("lat2.pass", 32'(pass), 32'(0));
    lat2 = 1'b0;
    repeat (3) @(posedge clk);

    for (int r = 0; r < 10; r++) begin
      for (int a = 0; a < N; a++) begin
        faultType[a] = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 3)) : 0;
        faultBit[a]  = int'($urandom_range(0, 7));
      end
      refModel();
      applyStimulus(1'b0, dc);
      checkResults($sformatf("rand%0d", r), dc, refCnt, refOvf, refPass, refTab);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
